// File: rtl/fifo_burst_pkg.sv
// Shared types and helpers for the FIFO burst reader.
//   state_t        : drain FSM encoding (IDLE / CMD / DATA)
//   calc_len_width : bits needed to hold a count 0..max_val (at least 1)
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  function automatic int calc_len_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Read-side drain engine for the synchronous valid/ready FIFO. Turns the
// FIFO word stream into length-tagged bursts: a command handshake carrying
// the burst length, then exactly that many data beats with last on the
// final one. Words stranded below the almost-full threshold are drained as
// single-beat bursts once the flush timer expires.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   fifo_valid_i        : FIFO not empty
//   fifo_ready_o        : FIFO pop
//   fifo_data_i         : FIFO head word
//   fifo_almost_full_i  : FIFO almost-full flag
//   cmd_valid_o/ready_i : burst command handshake
//   cmd_len_o           : beats in the commanded burst (BURST_LEN or 1)
//   out_valid_o/ready_i : data beat handshake
//   out_data_o          : data beat
//   out_last_o          : final beat of the burst
//   busy_o              : FSM not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | wait for almost-full (full burst) or flush + data (1 beat)
// CMD   | present cmd_valid_o with a frozen cmd_len_o until accepted
// DATA  | pass FIFO words through until beat_cnt beats are transferred
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter  int DATA_WIDTH    = 4,
  parameter  int BURST_LEN     = 4,
  parameter  int FLUSH_TIMEOUT = 16,
  localparam int LEN_WIDTH     = calc_len_width(BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_valid_i,
  output logic                  fifo_ready_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_almost_full_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [LEN_WIDTH-1:0]  cmd_len_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int                   TMR_WIDTH = calc_len_width(FLUSH_TIMEOUT);
  localparam logic [LEN_WIDTH-1:0] FULL_LEN  = LEN_WIDTH'(BURST_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE_LEN   = LEN_WIDTH'(1);
  localparam logic [TMR_WIDTH-1:0] TMR_LIMIT = TMR_WIDTH'(FLUSH_TIMEOUT);
  localparam logic [TMR_WIDTH-1:0] TMR_ONE   = TMR_WIDTH'(1);
  localparam bit                   FLUSH_EN  = (FLUSH_TIMEOUT > 0);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q, len_nxt;
  logic [LEN_WIDTH-1:0] beat_cnt, beat_cnt_nxt;
  logic [TMR_WIDTH-1:0] timer, timer_nxt;
  logic                 flush, flush_nxt;
  logic                 timer_run;
  logic                 out_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      beat_cnt <= '0;
      timer    <= '0;
      flush    <= 1'b0;
    end else begin
      state    <= state_nxt;
      len_q    <= len_nxt;
      beat_cnt <= beat_cnt_nxt;
      timer    <= timer_nxt;
      flush    <= flush_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    len_nxt      = len_q;
    beat_cnt_nxt = beat_cnt;
    cmd_valid_o  = 1'b0;
    fifo_ready_o = 1'b0;
    out_valid_o  = 1'b0;
    out_last_o   = 1'b0;
    out_hs       = 1'b0;
    unique case (state)
      IDLE: begin
        // Almost-full wins over flush so a filling FIFO is drained in
        // full bursts even if a flush was already pending.
        if (fifo_almost_full_i) begin
          state_nxt = CMD;
          len_nxt   = FULL_LEN;
        end else if (flush && fifo_valid_i) begin
          state_nxt = CMD;
          len_nxt   = ONE_LEN;
        end
      end
      CMD: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) begin
          state_nxt    = DATA;
          beat_cnt_nxt = len_q;
        end
      end
      DATA: begin
        out_valid_o  = fifo_valid_i;
        fifo_ready_o = out_ready_i;
        out_last_o   = (beat_cnt == ONE_LEN) && fifo_valid_i;
        out_hs       = fifo_valid_i && out_ready_i;
        if (out_hs) begin
          beat_cnt_nxt = beat_cnt - ONE_LEN;
          if (beat_cnt == ONE_LEN) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The timer only runs while words sit in the FIFO below threshold and no
  // flush is pending; any break in that condition restarts the count.
  assign timer_run = (state == IDLE) && fifo_valid_i && !fifo_almost_full_i && !flush;

  always_comb begin
    timer_nxt = '0;
    flush_nxt = flush;
    if (timer_run) begin
      timer_nxt = (timer == TMR_LIMIT) ? timer : timer + TMR_ONE;
    end
    if (state == IDLE) begin
      if (!fifo_valid_i || fifo_almost_full_i) begin
        flush_nxt = 1'b0;
      end else if (FLUSH_EN && timer_run && (timer_nxt == TMR_LIMIT)) begin
        flush_nxt = 1'b1;
      end
    end
  end

  assign cmd_len_o  = len_q;
  assign out_data_o = fifo_data_i;
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int DW        = 4;
  localparam int BL        = 4;
  localparam int FT        = 16;
  localparam int LW        = $clog2(BL + 1);
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_valid_i = 1'b0;
  logic          fifo_ready_o;
  logic [DW-1:0] fifo_data_i = '0;
  logic          fifo_almost_full_i = 1'b0;
  logic          cmd_valid_o;
  logic          cmd_ready_i = 1'b0;
  logic [LW-1:0] cmd_len_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;

  fifo_burst_reader #(
    .DATA_WIDTH   (DW),
    .BURST_LEN    (BL),
    .FLUSH_TIMEOUT(FT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fifo_valid_i      (fifo_valid_i),
    .fifo_ready_o      (fifo_ready_o),
    .fifo_data_i       (fifo_data_i),
    .fifo_almost_full_i(fifo_almost_full_i),
    .cmd_valid_o       (cmd_valid_o),
    .cmd_ready_i       (cmd_ready_i),
    .cmd_len_o         (cmd_len_o),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_data_o        (out_data_o),
    .out_last_o        (out_last_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural FIFO feeding the DUT; pushes/pops are committed at the
  // falling edge so the DUT samples a settled view on the rising edge.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] to_push[$];
  logic          pend_pop = 1'b0;
  logic          nxt_rst_n = 1'b0;
  logic          nxt_cmd_ready = 1'b0;
  logic          nxt_out_ready = 1'b0;

  int            cmd_len_log[$];
  int            cmd_cyc_log[$];
  logic [DW-1:0] beat_data_log[$];
  bit            beat_last_log[$];
  int            beat_cyc_log[$];
  int            pop_cnt = 0;
  int            rst_pops = 0;
  int            cmd_unstable = 0;
  logic          prev_cmd_valid = 1'b0;
  logic          prev_cmd_hs = 1'b0;
  logic [LW-1:0] prev_cmd_len = '0;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (pend_pop) void'(fifo_q.pop_front());
    while (to_push.size() > 0 && fifo_q.size() < DEPTH) fifo_q.push_back(to_push.pop_front());
    rst_n              = nxt_rst_n;
    cmd_ready_i        = nxt_cmd_ready;
    out_ready_i        = nxt_out_ready;
    fifo_valid_i       = (fifo_q.size() > 0);
    if (fifo_q.size() > 0) fifo_data_i = fifo_q[0];
    else                   fifo_data_i = '0;
    fifo_almost_full_i = (fifo_q.size() >= DEPTH - AF_MARGIN);
    #1;
    pend_pop = fifo_ready_o && fifo_valid_i;
    if (pend_pop) pop_cnt++;
    if (pend_pop && !rst_n) rst_pops++;
    if (rst_n && prev_cmd_valid && !prev_cmd_hs && (!cmd_valid_o || cmd_len_o != prev_cmd_len))
      cmd_unstable++;
    if (cmd_valid_o && cmd_ready_i) begin
      cmd_len_log.push_back(int'(cmd_len_o));
      cmd_cyc_log.push_back(cyc);
    end
    if (out_valid_o && out_ready_i) begin
      beat_data_log.push_back(out_data_o);
      beat_last_log.push_back(out_last_o);
      beat_cyc_log.push_back(cyc);
    end
    prev_cmd_valid = cmd_valid_o;
    prev_cmd_len   = cmd_len_o;
    prev_cmd_hs    = cmd_valid_o && cmd_ready_i;
  endtask

  task automatic clear_logs();
    cmd_len_log.delete();
    cmd_cyc_log.delete();
    beat_data_log.delete();
    beat_last_log.delete();
    beat_cyc_log.delete();
    pop_cnt = 0;
    rst_pops = 0;
    cmd_unstable = 0;
  endtask

  task automatic run_until_drained(input int max_steps, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_steps; i++) begin
      step();
      if (fifo_q.size() == 0 && to_push.size() == 0 && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nxt_rst_n = 1'b0;
    step();
    step();
    checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid_o); end
    checks++; if (cmd_len_o !== '0) begin errors++; $display("FAIL reset_cmd_len: got %0d want 0", cmd_len_o); end
    checks++; if (fifo_ready_o !== 1'b0) begin errors++; $display("FAIL reset_fifo_ready: got %b want 0", fifo_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    nxt_rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_burst();
    logic [DW-1:0] exp[$];
    int t_af;
    bit ok;
    clear_logs();
    nxt_cmd_ready = 1'b1;
    nxt_out_ready = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin exp.push_back(DW'(i)); to_push.push_back(DW'(i)); end
    step();
    t_af = cyc;
    run_until_drained(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_drain: got timeout want drained"); end
    checks++;
    if (cmd_len_log.size() != 1 || cmd_len_log[0] != BL) begin
      errors++; $display("FAIL full_cmd: got %0d cmds (first len %0d) want 1 cmd len %0d",
                         cmd_len_log.size(), (cmd_len_log.size() > 0) ? cmd_len_log[0] : -1, BL);
    end else begin
      checks++;
      if (cmd_cyc_log[0] != t_af + 1) begin
        errors++; $display("FAIL full_cmd_time: got cycle %0d want %0d", cmd_cyc_log[0], t_af + 1);
      end
    end
    checks++;
    if (beat_data_log.size() != 4) begin
      errors++; $display("FAIL full_beats: got %0d beats want 4", beat_data_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beat_data_log[i] !== exp[i] || beat_last_log[i] !== (i == 3)) begin
          errors++; $display("FAIL full_beat%0d: got data %h last %b want data %h last %b",
                             i, beat_data_log[i], beat_last_log[i], exp[i], (i == 3));
        end
      end
      checks++;
      if (beat_cyc_log[3] != t_af + 5) begin
        errors++; $display("FAIL full_duration: got last beat cycle %0d want %0d", beat_cyc_log[3], t_af + 5);
      end
    end
    checks++; if (fifo_q.size() != 0) begin errors++; $display("FAIL full_fifo_empty: got %0d words want 0", fifo_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp[$];
    int held_bad;
    bit ok;
    clear_logs();
    nxt_cmd_ready = 1'b0;
    nxt_out_ready = 1'b0;
    step();
    for (int i = 5; i <= 8; i++) begin exp.push_back(DW'(i)); to_push.push_back(DW'(i)); end
    step();
    held_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cmd_valid_o !== 1'b1 || cmd_len_o !== LW'(BL)) held_bad++;
    end
    checks++; if (held_bad != 0) begin errors++; $display("FAIL bp_cmd_hold: got %0d bad cycles want 0", held_bad); end
    nxt_cmd_ready = 1'b1;
    step();
    nxt_cmd_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nxt_out_ready = ~nxt_out_ready;
      step();
      if (fifo_q.size() == 0 && !busy_o) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got timeout want drained"); end
    checks++; if (cmd_unstable != 0) begin errors++; $display("FAIL bp_cmd_stable: got %0d changes want 0", cmd_unstable); end
    checks++; if (cmd_len_log.size() != 1) begin errors++; $display("FAIL bp_cmd_count: got %0d want 1", cmd_len_log.size()); end
    checks++; if (pop_cnt != 4) begin errors++; $display("FAIL bp_pops: got %0d want 4", pop_cnt); end
    checks++;
    if (beat_data_log.size() != 4) begin
      errors++; $display("FAIL bp_beats: got %0d beats want 4", beat_data_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beat_data_log[i] !== exp[i] || beat_last_log[i] !== (i == 3)) begin
          errors++; $display("FAIL bp_beat%0d: got data %h last %b want data %h last %b",
                             i, beat_data_log[i], beat_last_log[i], exp[i], (i == 3));
        end
      end
    end
    nxt_out_ready = 1'b1;
  endtask

  task automatic test_flush();
    int t0;
    int t1;
    bit ok;
    clear_logs();
    nxt_cmd_ready = 1'b1;
    nxt_out_ready = 1'b1;
    step();
    to_push.push_back(4'hA);
    to_push.push_back(4'hB);
    step();
    t0 = cyc;
    run_until_drained(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_drain: got timeout want drained"); end
    checks++;
    if (cmd_len_log.size() != 2 || cmd_len_log[0] != 1 || cmd_len_log[1] != 1) begin
      errors++; $display("FAIL flush_cmds: got %0d cmds want 2 of len 1", cmd_len_log.size());
    end else begin
      checks++;
      if (cmd_cyc_log[0] != t0 + FT + 1 || cmd_cyc_log[1] != t0 + FT + 4) begin
        errors++; $display("FAIL flush_timing: got cycles %0d,%0d want %0d,%0d",
                           cmd_cyc_log[0], cmd_cyc_log[1], t0 + FT + 1, t0 + FT + 4);
      end
    end
    checks++;
    if (beat_data_log.size() != 2 || beat_data_log[0] !== 4'hA || beat_data_log[1] !== 4'hB
        || beat_last_log[0] !== 1'b1 || beat_last_log[1] !== 1'b1) begin
      errors++; $display("FAIL flush_beats: got %0d beats want A,B each with last", beat_data_log.size());
    end
    // A fresh stranded word must wait the full timeout again, showing the
    // flush state was dropped once the FIFO emptied.
    to_push.push_back(4'hC);
    step();
    t1 = cyc;
    run_until_drained(40, ok);
    checks++;
    if (!ok || cmd_cyc_log.size() != 3 || cmd_len_log[2] != 1 || cmd_cyc_log[2] != t1 + FT + 1) begin
      errors++; $display("FAIL flush_cleared: got %0d cmds (last at %0d) want 3rd len 1 at cycle %0d",
                         cmd_cyc_log.size(), (cmd_cyc_log.size() > 0) ? cmd_cyc_log[cmd_cyc_log.size()-1] : -1,
                         t1 + FT + 1);
    end
  endtask

  task automatic test_priority();
    logic [DW-1:0] exp[$];
    int t0;
    bit ok;
    clear_logs();
    nxt_cmd_ready = 1'b1;
    nxt_out_ready = 1'b1;
    step();
    exp = '{4'hD, 4'hE, 4'hF, 4'h0};
    to_push.push_back(exp[0]);
    step();
    t0 = cyc;
    for (int i = 0; i < FT - 1; i++) step();
    // Flush is now pending; almost-full arrives in the same IDLE decision.
    for (int i = 1; i < 4; i++) to_push.push_back(exp[i]);
    step();
    run_until_drained(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_drain: got timeout want drained"); end
    checks++;
    if (cmd_len_log.size() < 1 || cmd_len_log[0] != BL) begin
      errors++; $display("FAIL prio_len: got %0d cmds first len %0d want len %0d",
                         cmd_len_log.size(), (cmd_len_log.size() > 0) ? cmd_len_log[0] : -1, BL);
    end else begin
      checks++;
      if (cmd_len_log.size() != 1 || cmd_cyc_log[0] != t0 + FT + 1) begin
        errors++; $display("FAIL prio_cmd: got %0d cmds at %0d want 1 at %0d",
                           cmd_len_log.size(), cmd_cyc_log[0], t0 + FT + 1);
      end
    end
    checks++;
    if (beat_data_log.size() != 4) begin
      errors++; $display("FAIL prio_beats: got %0d want 4", beat_data_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beat_data_log[i] !== exp[i] || beat_last_log[i] !== (i == 3)) begin
          errors++; $display("FAIL prio_beat%0d: got %h/%b want %h/%b",
                             i, beat_data_log[i], beat_last_log[i], exp[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp[$];
    bit ok;
    clear_logs();
    nxt_cmd_ready = 1'b1;
    nxt_out_ready = 1'b1;
    step();
    exp = '{4'h3, 4'h9, 4'h6, 4'hC, 4'h7, 4'h8};
    for (int i = 0; i < 4; i++) to_push.push_back(exp[i]);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (beat_data_log.size() == 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_reach: got %0d beats want 2", beat_data_log.size()); end
    nxt_rst_n = 1'b0;
    step();
    checks++;
    if ({cmd_valid_o, cmd_len_o, fifo_ready_o, out_valid_o, out_last_o, busy_o} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got cv=%b len=%0d fr=%b ov=%b ol=%b busy=%b want all 0",
                         cmd_valid_o, cmd_len_o, fifo_ready_o, out_valid_o, out_last_o, busy_o);
    end
    step();
    step();
    checks++; if (rst_pops != 0) begin errors++; $display("FAIL rst_mid_pops: got %0d pops in reset want 0", rst_pops); end
    checks++; if (fifo_q.size() != 2) begin errors++; $display("FAIL rst_mid_fifo: got %0d words want 2", fifo_q.size()); end
    nxt_rst_n = 1'b1;
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got busy %b want 0", busy_o); end
    to_push.push_back(exp[4]);
    to_push.push_back(exp[5]);
    run_until_drained(30, ok);
    checks++;
    if (!ok || cmd_len_log.size() != 2 || cmd_len_log[1] != BL) begin
      errors++; $display("FAIL rst_mid_restart: got %0d cmds want 2 (second len %0d)", cmd_len_log.size(), BL);
    end
    checks++;
    if (beat_data_log.size() != 6) begin
      errors++; $display("FAIL rst_mid_beats: got %0d want 6", beat_data_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (beat_data_log[i] !== exp[i] || beat_last_log[i] !== (i == 5)) begin
          errors++; $display("FAIL rst_mid_beat%0d: got %h/%b want %h/%b",
                             i, beat_data_log[i], beat_last_log[i], exp[i], (i == 5));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp[$];
    logic [DW-1:0] w;
    int bad_data;
    int bad_last;
    int bad_len;
    int idx;
    int len_sum;
    bit ok;
    clear_logs();
    for (int i = 0; i < 800; i++) begin
      nxt_cmd_ready = ($urandom_range(0, 3) != 0);
      nxt_out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && fifo_q.size() + to_push.size() < DEPTH) begin
        w = DW'($urandom_range(0, 15));
        exp.push_back(w);
        to_push.push_back(w);
      end
      step();
    end
    nxt_cmd_ready = 1'b1;
    nxt_out_ready = 1'b1;
    run_until_drained(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rnd_drain: got timeout want drained"); end
    checks++;
    if (beat_data_log.size() != exp.size()) begin
      errors++; $display("FAIL rnd_count: got %0d beats want %0d", beat_data_log.size(), exp.size());
    end else begin
      bad_data = 0;
      for (int i = 0; i < exp.size(); i++) if (beat_data_log[i] !== exp[i]) bad_data++;
      checks++; if (bad_data != 0) begin errors++; $display("FAIL rnd_order: got %0d wrong words want 0", bad_data); end
    end
    bad_len = 0;
    bad_last = 0;
    len_sum = 0;
    idx = 0;
    foreach (cmd_len_log[c]) begin
      if (cmd_len_log[c] != 1 && cmd_len_log[c] != BL) bad_len++;
      len_sum += cmd_len_log[c];
      for (int k = 0; k < cmd_len_log[c]; k++) begin
        if (idx < beat_last_log.size() && beat_last_log[idx] !== (k == cmd_len_log[c] - 1)) bad_last++;
        idx++;
      end
    end
    checks++; if (bad_len != 0) begin errors++; $display("FAIL rnd_len: got %0d illegal lengths want 0", bad_len); end
    checks++; if (len_sum != beat_data_log.size()) begin errors++; $display("FAIL rnd_len_sum: got %0d want %0d", len_sum, beat_data_log.size()); end
    checks++; if (bad_last != 0) begin errors++; $display("FAIL rnd_last: got %0d wrong last flags want 0", bad_last); end
    checks++; if (cmd_unstable != 0) begin errors++; $display("FAIL rnd_cmd_stable: got %0d changes want 0", cmd_unstable); end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_backpressure();
    test_flush();
    test_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
